// File: rtl/operand_queue_shared_pkg.sv
// Shared types and helpers for the VRF operand queue that fans one read port out
// to several functional units.
package operand_queue_shared_pkg;

    // Target encoding when the queue feeds the classic slide/addrgen pair.
    typedef enum logic [0:0] {
        SLDU_TGT    = 1'b0,
        ADDRGEN_TGT = 1'b1
    } target_fu_e;

    function automatic int unsigned tgt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/operand_queue_shared_fifo.sv
// Small synchronous FIFO with flush and occupancy count; no fall-through, so a
// push becomes visible at the head on the following cycle.
module operand_queue_shared_fifo #(
    parameter  int unsigned Depth = 2,
    parameter  int unsigned Width = 8,
    localparam int unsigned PtrW  = (Depth > 1) ? $clog2(Depth) : 1,
    localparam int unsigned CntW  = $clog2(Depth + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [Width-1:0] data_i,
    input  logic             pop_i,
    output logic [Width-1:0] data_o,
    output logic             empty_o,
    output logic [CntW-1:0]  usage_o
);

    logic [Depth-1:0][Width-1:0] mem_q;
    logic [PtrW-1:0]             rd_ptr_q, wr_ptr_q;
    logic [CntW-1:0]             cnt_q;
    logic                        do_push, do_pop;

    function automatic logic [PtrW-1:0] incr(input logic [PtrW-1:0] p);
        return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty_o = (cnt_q == '0);
    assign usage_o = cnt_q;
    // A full FIFO refuses a push even when it is popped in the same cycle.
    assign do_push = push_i & (cnt_q != CntW'(Depth));
    assign do_pop  = pop_i & ~empty_o;
    assign data_o  = mem_q[rd_ptr_q];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mem_q    <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
        end else if (flush_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= data_i;
                wr_ptr_q        <= incr(wr_ptr_q);
            end
            if (do_pop) rd_ptr_q <= incr(rd_ptr_q);
            cnt_q <= cnt_q + CntW'(do_push) - CntW'(do_pop);
        end
    end

endmodule

// File: rtl/operand_queue_shared.sv
// Operand queue sharing one VRF read port among NrTargets consumers, with
// per-command routing, credit-based issue control and a flush that drops stale reads.
module operand_queue_shared import operand_queue_shared_pkg::*; #(
    parameter int unsigned NrTargets    = 2,
    parameter int unsigned DataBufDepth = 2,
    parameter int unsigned CmdBufDepth  = 4,
    parameter int unsigned DataWidth    = 64,
    parameter int unsigned LenWidth     = 16,
    parameter int unsigned TgtWidth     = tgt_width(NrTargets)
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         flush_i,
    input  logic [TgtWidth+LenWidth-1:0] cmd_i,
    input  logic                         cmd_valid_i,
    output logic                         cmd_ready_o,
    input  logic                         operand_issued_i,
    output logic                         operand_queue_ready_o,
    input  logic [DataWidth-1:0]         operand_i,
    input  logic                         operand_valid_i,
    output logic [DataWidth-1:0]         operand_o,
    output logic [TgtWidth-1:0]          operand_target_o,
    output logic                         operand_valid_o,
    input  logic [NrTargets-1:0]         operand_ready_i
);

    typedef struct packed {
        logic [TgtWidth-1:0] target;
        logic [LenWidth-1:0] len;
    } cmd_t;

    localparam int unsigned CntW    = $clog2(DataBufDepth + 1);
    localparam int unsigned CmdCntW = $clog2(CmdBufDepth + 1);

    cmd_t                cmd_in, cmd_head;
    logic                cmd_empty, data_empty;
    logic [CmdCntW-1:0]  cmd_usage;
    logic [CntW-1:0]     data_usage, inflight_q, inflight_d, credits;
    logic [LenWidth-1:0] elem_cnt_q;
    logic                drop_q, tgt_ok, pop, cmd_last, cmd_push, data_push;

    assign cmd_in = cmd_i;

    // Stale reads still in flight after a flush hold their credit until they return.
    assign credits               = CntW'(DataBufDepth) - data_usage - inflight_q;
    assign operand_queue_ready_o = (credits != '0);
    assign cmd_ready_o           = (cmd_usage != CmdCntW'(CmdBufDepth));

    assign operand_valid_o  = ~data_empty & ~cmd_empty;
    assign operand_target_o = cmd_head.target;
    assign tgt_ok           = (32'(cmd_head.target) < NrTargets);
    assign pop              = operand_valid_o & tgt_ok & operand_ready_i[cmd_head.target];
    assign cmd_last         = (elem_cnt_q == cmd_head.len - LenWidth'(1));
    assign cmd_push         = cmd_valid_i & cmd_ready_o;
    assign data_push        = operand_valid_i & ~drop_q;

    always_comb begin
        inflight_d = inflight_q;
        if (operand_issued_i && !operand_valid_i)      inflight_d = inflight_q + 1'b1;
        else if (!operand_issued_i && operand_valid_i) inflight_d = inflight_q - 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            elem_cnt_q <= '0;
            inflight_q <= '0;
            drop_q     <= 1'b0;
        end else begin
            inflight_q <= inflight_d;
            if (flush_i) begin
                elem_cnt_q <= '0;
                drop_q     <= (inflight_d != '0);
            end else begin
                if (pop) elem_cnt_q <= cmd_last ? '0 : elem_cnt_q + 1'b1;
                if (drop_q && inflight_d == '0) drop_q <= 1'b0;
            end
        end
    end

    operand_queue_shared_fifo #(
        .Depth (DataBufDepth),
        .Width (DataWidth)
    ) i_data_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .flush_i (flush_i),
        .push_i  (data_push),
        .data_i  (operand_i),
        .pop_i   (pop),
        .data_o  (operand_o),
        .empty_o (data_empty),
        .usage_o (data_usage)
    );

    operand_queue_shared_fifo #(
        .Depth (CmdBufDepth),
        .Width ($bits(cmd_t))
    ) i_cmd_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .flush_i (flush_i),
        .push_i  (cmd_push),
        .data_i  (cmd_in),
        .pop_i   (pop & cmd_last),
        .data_o  (cmd_head),
        .empty_o (cmd_empty),
        .usage_o (cmd_usage)
    );

    a_issue_credit: assert property (@(posedge clk_i) disable iff (!rst_ni)
        operand_issued_i |-> credits != '0);
    a_data_not_full: assert property (@(posedge clk_i) disable iff (!rst_ni)
        data_push |-> data_usage != CntW'(DataBufDepth));
    a_cmd_len_nonzero: assert property (@(posedge clk_i) disable iff (!rst_ni)
        cmd_push |-> cmd_in.len != '0);

endmodule

// File: tb/tb_operand_queue_shared.sv
// Bench for operand_queue_shared: directed scenarios with literal expectations,
// then random traffic checked every cycle against a queue-based model.
module tb_operand_queue_shared;

    localparam int NT = 2, DBD = 2, CBD = 4, DW = 64, LW = 16, TW = 1;

    logic            clk = 1'b0, rst_n = 1'b0;
    logic            flush, cmd_valid, issued, op_valid_in;
    logic [TW+LW-1:0] cmd;
    logic [DW-1:0]   op_in;
    logic [NT-1:0]   ready;
    logic            cmd_ready, oq_ready, op_valid;
    logic [DW-1:0]   op_out;
    logic [TW-1:0]   op_tgt;

    always #5 clk = ~clk;

    operand_queue_shared #(
        .NrTargets(NT), .DataBufDepth(DBD), .CmdBufDepth(CBD), .DataWidth(DW), .LenWidth(LW)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
        .cmd_i(cmd), .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
        .operand_issued_i(issued), .operand_queue_ready_o(oq_ready),
        .operand_i(op_in), .operand_valid_i(op_valid_in),
        .operand_o(op_out), .operand_target_o(op_tgt), .operand_valid_o(op_valid),
        .operand_ready_i(ready)
    );

    typedef struct { int tgt; int len; } mcmd_t;
    logic [DW-1:0] m_data[$];
    mcmd_t         m_cmd[$];
    int            m_inflight, m_elem;
    bit            m_drop;
    int            checks = 0, errors = 0;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_data.delete(); m_cmd.delete();
        m_inflight = 0; m_elem = 0; m_drop = 0;
    endtask

    // One clock of the queue's rules, applied to the inputs held across the edge.
    task automatic model_step();
        bit    pop, acc;
        int    infl_n;
        mcmd_t c;
        pop    = (m_data.size() > 0) && (m_cmd.size() > 0) && ready[m_cmd[0].tgt];
        acc    = cmd_valid && (m_cmd.size() < CBD);
        infl_n = m_inflight + int'(issued) - int'(op_valid_in);
        if (flush) begin
            m_data.delete(); m_cmd.delete();
            m_elem = 0;
            m_drop = (infl_n != 0);
        end else begin
            if (pop) begin
                void'(m_data.pop_front());
                m_elem++;
                if (m_elem == m_cmd[0].len) begin
                    void'(m_cmd.pop_front());
                    m_elem = 0;
                end
            end
            if (op_valid_in && !m_drop) m_data.push_back(op_in);
            if (acc) begin
                c.tgt = int'(cmd[LW+TW-1:LW]);
                c.len = int'(cmd[LW-1:0]);
                m_cmd.push_back(c);
            end
            if (m_drop && infl_n == 0) m_drop = 0;
        end
        m_inflight = infl_n;
    endtask

    task automatic compare_all();
        bit v;
        v = (m_data.size() > 0) && (m_cmd.size() > 0);
        chk("cmd_ready", cmd_ready, (m_cmd.size() < CBD));
        chk("queue_ready", oq_ready, ((DBD - m_data.size() - m_inflight) != 0));
        chk("valid", op_valid, v);
        if (v) begin
            chk("operand", op_out, m_data[0]);
            chk("target", op_tgt, m_cmd[0].tgt);
        end
    endtask

    task automatic drive(input bit fl, input bit cv, input int tgt, input int len,
                         input bit iss, input bit vv, input logic [DW-1:0] d, input logic [NT-1:0] rdy);
        flush = fl; cmd_valid = cv; cmd = {TW'(tgt), LW'(len)};
        issued = iss; op_valid_in = vv; op_in = d; ready = rdy;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, '0, '0);
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    initial begin
        int credits;
        idle();
        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_queue_ready", oq_ready, 1);
        chk("rst_valid", op_valid, 0);
        chk("rst_operand", op_out, 0);
        chk("rst_target", op_tgt, 0);

        // Basic routing: {1,3}, A,B,C; non-target readies ignored.
        drive(0, 1, 1, 3, 1, 0, '0, 2'b00); step();
        drive(0, 0, 0, 0, 1, 0, '0, 2'b00); step();
        chk("route_no_credit", oq_ready, 0);
        drive(0, 0, 0, 0, 0, 1, 64'hA, 2'b01); step();
        chk("route_valid_A", op_valid, 1);
        chk("route_op_A", op_out, 64'hA);
        chk("route_tgt", op_tgt, 1);
        drive(0, 0, 0, 0, 0, 1, 64'hB, 2'b01); step();
        chk("route_ignore_other", op_out, 64'hA);
        drive(0, 0, 0, 0, 0, 0, '0, 2'b10); step();
        chk("route_op_B", op_out, 64'hB);
        drive(0, 0, 0, 0, 1, 0, '0, 2'b10); step();
        chk("route_empty", op_valid, 0);
        drive(0, 0, 0, 0, 0, 1, 64'hC, 2'b00); step();
        chk("route_op_C", op_out, 64'hC);
        drive(0, 0, 0, 0, 0, 0, '0, 2'b10); step();
        chk("route_retired", op_valid, 0);

        // Credits: two issues exhaust the pool; return plus pop frees one.
        drive(0, 1, 0, 2, 1, 0, '0, 2'b00); step();
        drive(0, 0, 0, 0, 1, 0, '0, 2'b00); step();
        chk("cred_zero", oq_ready, 0);
        drive(0, 0, 0, 0, 0, 1, 64'h11, 2'b00); step();
        chk("cred_still_zero", oq_ready, 0);
        drive(0, 0, 0, 0, 0, 1, 64'h22, 2'b01); step();
        chk("cred_freed", oq_ready, 1);
        chk("cred_op", op_out, 64'h22);
        drive(0, 0, 0, 0, 0, 0, '0, 2'b01); step();

        // Back-to-back commands {0,1},{1,2} with data X,Y,Z.
        drive(0, 1, 0, 1, 1, 0, '0, 2'b11); step();
        drive(0, 1, 1, 2, 1, 0, '0, 2'b11); step();
        drive(0, 0, 0, 0, 0, 1, 64'h5A, 2'b11); step();
        chk("b2b_X", op_out, 64'h5A);
        chk("b2b_X_tgt", op_tgt, 0);
        drive(0, 0, 0, 0, 0, 1, 64'h5B, 2'b11); step();
        chk("b2b_Y", op_out, 64'h5B);
        chk("b2b_Y_tgt", op_tgt, 1);
        drive(0, 0, 0, 0, 1, 0, '0, 2'b11); step();
        drive(0, 0, 0, 0, 0, 1, 64'h5C, 2'b11); step();
        chk("b2b_Z", op_out, 64'h5C);
        chk("b2b_Z_tgt", op_tgt, 1);
        drive(0, 0, 0, 0, 0, 0, '0, 2'b11); step();

        // Flush with two reads in flight; the command pushed during flush is lost.
        drive(0, 0, 0, 0, 1, 0, '0, 2'b00); step();
        drive(0, 0, 0, 0, 1, 0, '0, 2'b00); step();
        drive(1, 1, 0, 1, 0, 0, '0, 2'b11); step();
        chk("flush_valid", op_valid, 0);
        chk("flush_credits", oq_ready, 0);
        drive(0, 0, 0, 0, 0, 1, 64'hDEAD, 2'b11); step();
        chk("stale1_dropped", op_valid, 0);
        drive(0, 0, 0, 0, 0, 1, 64'hBEEF, 2'b11); step();
        chk("stale2_dropped", op_valid, 0);
        chk("drop_credits_back", oq_ready, 1);
        drive(0, 0, 0, 0, 1, 0, '0, 2'b00); step();
        drive(0, 0, 0, 0, 0, 1, 64'hD, 2'b00); step();
        chk("flush_cmd_discarded", op_valid, 0);
        drive(0, 1, 0, 1, 0, 0, '0, 2'b00); step();
        chk("post_flush_valid", op_valid, 1);
        chk("post_flush_D", op_out, 64'hD);
        drive(0, 0, 0, 0, 0, 0, '0, 2'b01); step();

        // Command FIFO full; a push while the head retires is still refused.
        drive(0, 1, 0, 1, 1, 0, '0, 2'b00); step();
        drive(0, 1, 0, 1, 0, 1, 64'hE, 2'b00); step();
        drive(0, 1, 0, 1, 0, 0, '0, 2'b00); step();
        drive(0, 1, 0, 1, 0, 0, '0, 2'b00); step();
        chk("cmd_full", cmd_ready, 0);
        drive(0, 1, 1, 1, 0, 0, '0, 2'b11); step();
        chk("cmd_refused_ready", cmd_ready, 1);
        drive(1, 0, 0, 0, 0, 0, '0, 2'b00); step();

        // Asynchronous reset mid-burst.
        drive(0, 1, 0, 2, 1, 0, '0, 2'b00); step();
        drive(0, 0, 0, 0, 1, 0, '0, 2'b00); step();
        drive(0, 0, 0, 0, 0, 1, 64'hF, 2'b00); step();
        chk("burst_valid", op_valid, 1);
        idle();
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", op_valid, 0);
        chk("arst_operand", op_out, 0);
        chk("arst_target", op_tgt, 0);
        chk("arst_cmd_ready", cmd_ready, 1);
        chk("arst_queue_ready", oq_ready, 1);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("rel_queue_ready", oq_ready, 1);

        // Random traffic; issues only when credits exist, returns only when reads are out.
        for (int i = 0; i < 3000; i++) begin
            credits = DBD - m_data.size() - m_inflight;
            drive($urandom_range(0, 59) == 0, $urandom_range(0, 1) == 1,
                  $urandom_range(0, 1), $urandom_range(1, 3),
                  (credits > 0) && ($urandom_range(0, 1) == 1),
                  (m_inflight > 0) && ($urandom_range(0, 2) != 0),
                  {$urandom, $urandom}, NT'($urandom_range(0, 3)));
            step();
        end
        idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
